button_debounce_reader: RTL and testbench
=========================================

// Module: button_debounce_reader
// PURPOSE
//  Input-side counterpart to the LED drivers: samples an asynchronous board pin (push-button/switch),
//  synchronizes and debounces it, and reports clean press/release events, long-press and press duration.
//  Runs on the 10 kHz SB_LFOSC clock. Feeds mode-select/control logic in top-level designs.
// PARAMETERS
//  DEBOUNCE_CYCLES  100    stable cycles required to accept a level change (10 ms @ 10 kHz); >=1
//  LONG_CYCLES      10000  press length (cycles) that fires long_press_pulse (1 s); >=1
//  DUR_WIDTH        16     width of duration counter/output
//  ACTIVE_LOW       1      1: pin low = pressed (pull-up board wiring); 0: pin high = pressed
// PORTS
//  clk               input   1          single clock, SB_LFOSC CLKLF domain
//  rst_n             input   1          synchronous, active-low reset
//  pin_in            input   1          raw asynchronous pin
//  level             output  1          debounced pressed state (1 = pressed)
//  press_pulse       output  1          one-cycle strobe on accepted press
//  release_pulse     output  1          one-cycle strobe on accepted release
//  long_press_pulse  output  1          one-cycle strobe, at most once per press
//  duration          output  DUR_WIDTH  cycles from press_pulse to release_pulse, saturating
//  duration_valid    output  1          one-cycle strobe, coincident with release_pulse
// BEHAVIOUR
//  - Reset (rst_n low at posedge): sync flops load inactive level; state RELEASED; debounce/duration counters 0;
//    all outputs 0. Reset mid-press discards the press: no release/duration emitted; if pin still active
//    after reset, a full debounce runs and a fresh press_pulse follows.
//  - Sync: 2-FF synchronizer, polarity normalized so sample s=1 means pressed. Edge k = first edge capturing
//    the new pin level; FSM sees it at edge k+2.
//  - FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND. Debounce cnt cleared on every PEND entry.
//    RELEASED: s=1 -> PRESS_PEND. PRESS_PEND: s=0 -> RELEASED (bounce, no event); s=1 and cnt==DEBOUNCE_CYCLES-1
//    -> PRESSED, press_pulse=1, level=1, dur_cnt=0; else cnt++.
//    PRESSED: s=0 -> RELEASE_PEND. RELEASE_PEND: s=1 -> PRESSED (bounce, no event, dur_cnt keeps counting);
//    s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse=1, level=0, duration<=dur_cnt, duration_valid=1.
//  - Latency: press_pulse/release_pulse high in the cycle after edge k+DEBOUNCE_CYCLES+2 (clean input).
//  - level changes on the same edge as its strobe; strobes are exactly one cycle, all outputs registered.
//  - dur_cnt increments each edge in PRESSED/RELEASE_PEND (release debounce included); saturates at 2^DUR_WIDTH-1,
//    never wraps. duration holds last value until next release.
//  - long_press_pulse: when dur_cnt increments to LONG_CYCLES (and long_fired==0); long_fired set, cleared on press.
//    If LONG_CYCLES > 2^DUR_WIDTH-1, long press never fires (saturated counter cannot match).
//  - Bounce resets cnt; DEBOUNCE_CYCLES==1 accepts after one stable cycle. Counter widths via $clog2.
// STRUCTURE
//  - Shared include c0_io_defs.vh: FSM state localparams (2-bit encoding), default debounce/long constants
//    for the 10 kHz clock.
//  - Sub-module pin_synchronizer (2-FF, reset value parameter) reused by other pin-input blocks.
//  - FSM, debounce counter, duration/long logic in this module.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DUR_WIDTH=8, ACTIVE_LOW=1)
//  1 Clean press: pin 1->0 captured at edge k -> press_pulse, level=1 after edge k+6; no other strobe.
//  2 Bounce: pin low 2 cycles, high 1, low steady -> exactly one press_pulse, 6 edges after last low capture.
//  3 Release after 10-cycle hold -> release_pulse & duration_valid same cycle, duration=10, level=0, no long pulse.
//  4 Hold 30 cycles -> single long_press_pulse when dur_cnt hits 20; duration=30 at release; next press re-arms.
//  5 Hold 300 cycles -> duration saturates at 255.
//  6 rst_n low mid-press with pin held low -> outputs 0, no release; press_pulse again 6 edges after reset release.

Source files
------------

// File: rtl/button_debounce_reader_pkg.sv
// Shared definitions for pin-input blocks: debounce FSM states and the
// default timing constants for the 10 kHz low-frequency oscillator clock.
package button_debounce_reader_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 100;    // 10 ms at 10 kHz
  localparam int DEF_LONG_CYCLES     = 10000;  // 1 s at 10 kHz

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce_reader_sync.sv
// Two-flop synchronizer for an asynchronous board pin; the reset value lets
// each instance park at its pin's idle level.
module pin_synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic sync
);

  logic meta;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // meta and sync update together and form a real two-stage shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
    end else begin
      meta <= pin_in;
      sync <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_reader.sv
// Push-button reader: synchronizes and debounces a pin, then reports press,
// release, long-press strobes and the saturating press duration.
module button_debounce_reader
  import button_debounce_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int DUR_WIDTH       = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin_in,
  output logic                 level,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic                 long_press_pulse,
  output logic [DUR_WIDTH-1:0] duration,
  output logic                 duration_valid
);

  localparam int                   CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DUR_WIDTH-1:0] DUR_MAX  = '1;

  logic                 pin_sync;
  logic                 s;
  btn_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic [DUR_WIDTH-1:0] dur_next;
  logic                 long_fired;
  logic                 long_hit;

  pin_synchronizer #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (pin_in),
    .sync   (pin_sync)
  );

  assign s = ACTIVE_LOW ? ~pin_sync : pin_sync;

  // A saturated counter never reaches a LONG_CYCLES beyond its range, so an
  // oversized threshold simply never fires.
  assign dur_next = (dur_cnt == DUR_MAX) ? dur_cnt : dur_cnt + 1'b1;
  assign long_hit = (dur_cnt != DUR_MAX) && ((int'(dur_cnt) + 1) == LONG_CYCLES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= RELEASED;
      cnt              <= '0;
      dur_cnt          <= '0;
      long_fired       <= 1'b0;
      level            <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      duration         <= '0;
      duration_valid   <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      duration_valid   <= 1'b0;

      // The press is still live while the release is being debounced.
      if (state == PRESSED || state == RELEASE_PEND) begin
        dur_cnt <= dur_next;
        if (long_hit && !long_fired) begin
          long_press_pulse <= 1'b1;
          long_fired       <= 1'b1;
        end
      end

      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_PEND;
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!s) begin
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            level       <= 1'b1;
            dur_cnt     <= '0;
            long_fired  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_PEND;
            cnt   <= '0;
          end
        end
        RELEASE_PEND: begin
          if (s) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state          <= RELEASED;
            release_pulse  <= 1'b1;
            level          <= 1'b0;
            duration       <= dur_next;
            duration_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Randomized bench for button_debounce_reader, compared every cycle against a
// run-length model of debounce and an elapsed-time model of press duration.
module tb_button_debounce_reader;

  localparam int D       = 4;
  localparam int LONG    = 20;
  localparam int DW      = 8;
  localparam int DUR_SAT = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pin_in;
  logic          level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_press_pulse;
  logic [DW-1:0] duration;
  logic          duration_valid;

  int vectors   = 0;
  int miscompares = 0;

  // Reference model state: pin history, accepted level, run of disagreeing
  // samples, cycles since the accepted press.
  logic m_d0, m_d1;
  logic m_level, m_press, m_release, m_long, m_dv;
  int   m_run, m_elapsed, m_duration;

  button_debounce_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (LONG),
    .DUR_WIDTH       (DW),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pin_in           (pin_in),
    .level            (level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .duration         (duration),
    .duration_valid   (duration_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock edge of the reference: the FSM sees the pin as captured two
  // edges earlier; a level change is accepted after D+1 agreeing samples.
  task automatic model_edge(input logic r, input logic p);
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0; m_dv = 1'b0;
    if (!r) begin
      m_d0 = 1'b0; m_d1 = 1'b0;
      m_level = 1'b0; m_run = 0; m_elapsed = 0; m_duration = 0;
    end else begin
      logic smp;
      smp  = m_d1;
      m_d1 = m_d0;
      m_d0 = ~p;
      if (m_level) begin
        m_elapsed++;
        if (m_elapsed == LONG) m_long = 1'b1;
      end
      m_run = (smp != m_level) ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_run   = 0;
        m_level = smp;
        if (smp) begin
          m_press   = 1'b1;
          m_elapsed = 0;
        end else begin
          m_release  = 1'b1;
          m_dv       = 1'b1;
          m_duration = (m_elapsed > DUR_SAT) ? DUR_SAT : m_elapsed;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic p);
    rst_n  = r;
    pin_in = p;
    @(posedge clk);
    model_edge(r, p);
    @(negedge clk);
    check("level",          int'(level),            int'(m_level));
    check("press_pulse",    int'(press_pulse),      int'(m_press));
    check("release_pulse",  int'(release_pulse),    int'(m_release));
    check("long_pulse",     int'(long_press_pulse), int'(m_long));
    check("duration_valid", int'(duration_valid),   int'(m_dv));
    check("duration",       int'(duration),         m_duration);
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, p);
  endtask

  initial begin
    int len;
    logic lvl;

    m_d0 = 1'b0; m_d1 = 1'b0;
    m_level = 1'b0; m_run = 0; m_elapsed = 0; m_duration = 0;

    // Reset with the pin idle (high).
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    hold(1'b1, 5);

    // Clean press and release after a 10-cycle hold.
    hold(1'b0, 10);
    hold(1'b1, 12);
    // Bounce on press: low 2, high 1, then steady low.
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 15);
    // Bounce on release while pressed.
    hold(1'b1, 2);
    hold(1'b0, 3);
    hold(1'b1, 12);
    // Long press, then a second one to show re-arming.
    hold(1'b0, 30);
    hold(1'b1, 12);
    hold(1'b0, 30);
    hold(1'b1, 12);
    // Saturating duration.
    hold(1'b0, 300);
    hold(1'b1, 12);
    // Reset mid-press with the pin still held low.
    hold(1'b0, 12);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    hold(1'b0, 15);
    hold(1'b1, 12);

    // Random segments: short bounces, ordinary holds, occasional resets.
    lvl = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      lvl = ~lvl;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: len = $urandom_range(1, 6);
        9:          len = $urandom_range(1, 3);
        default:    len = $urandom_range(1, 40);
      endcase
      if ($urandom_range(0, 9) == 9) begin
        for (int i = 0; i < len; i++) cycle(1'b0, lvl);
      end else begin
        hold(lvl, len);
      end
    end
    hold(1'b1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
